// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);
endpackage

// File: rtl/seq_divider_8_div_step.sv
// One shift-subtract step of the restoring divider, purely combinational.
import div_pkg::*;

module div_step (
  input  logic [DIV_WIDTH:0]   r_in,
  input  logic                 q_msb,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH:0]   r_out,
  output logic                 q_bit
);
  logic [DIV_WIDTH:0]   t;
  logic [DIV_WIDTH+1:0] d;

  // Subtract is one bit wider than the partial remainder so its MSB is a true borrow.
  always_comb begin
    t     = {r_in[DIV_WIDTH-1:0], q_msb};
    d     = {1'b0, t} - {2'b00, dvs};
    q_bit = ~d[DIV_WIDTH+1];
    r_out = q_bit ? d[DIV_WIDTH:0] : t;
  end
endmodule

// File: rtl/seq_divider_8.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results registered on DONE entry.
// Handshake: Start is a level request sampled only in IDLE; Done stays high while Start is held, and
// the FSM returns to IDLE on the first edge that sees Start low.
import div_pkg::*;

module seq_divider_8 (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [DIV_WIDTH-1:0] Dividend,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic [DIV_WIDTH-1:0] Quotient,
  output logic [DIV_WIDTH-1:0] Remainder,
  output logic                 Busy,
  output logic                 Done,
  output logic                 DivZero,
  output logic [1:0]           dbg_state
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_WIDTH - 1);

  div_state_t           state_q, state_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH:0]   r_q, r_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIV_WIDTH:0]   step_r;
  logic                 step_bit;

  div_step u_step (
    .r_in  (r_q),
    .q_msb (q_q[DIV_WIDTH-1]),
    .dvs   (dvs_q),
    .r_out (step_r),
    .q_bit (step_bit)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = LOAD;
          dvd_d   = Dividend;
          dvs_d   = Divisor;
        end
      end
      LOAD: begin
        if (dvs_q == '0) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = dvd_q;
          dz_d    = 1'b1;
        end else begin
          state_d = ITER;
          r_d     = '0;
          q_d     = dvd_q;
          cnt_d   = '0;
          dz_d    = 1'b0;
        end
      end
      ITER: begin
        r_d = step_r;
        q_d = {q_q[DIV_WIDTH-2:0], step_bit};
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          quot_d  = {q_q[DIV_WIDTH-2:0], step_bit};
          rem_d   = step_r[DIV_WIDTH-1:0];
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == ITER);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: directed corner cases plus random operands against a/b, a%b.
module tb_seq_divider_8;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_zero;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [16:0] exp_q[$];

  seq_divider_8 dut (
    .Clk       (clk),
    .Reset     (rst),
    .Start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivZero   (div_zero),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Expected {div_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    if (b == 0) return {1'b1, 8'hFF, a};
    return {1'b0, 8'(a / b), 8'(a % b)};
  endfunction

  // Starts an op from IDLE and waits for Done, leaving Start high.
  // lat counts edges from the start edge (inclusive) to the edge after which Done is first seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output logic busy_ok);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = 0;
    busy_ok  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    if (!done) lat = -1;
  endtask

  task automatic end_op();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({quotient, remainder, busy, done, div_zero, dbg_state} !== 21'd0) begin
      n_fails++;
      $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b dz=%b st=%0d, want all zero",
               quotient, remainder, busy, done, div_zero, dbg_state);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta[5] = '{8'd100, 8'd255, 8'd255, 8'd5, 8'd10};
    logic [7:0] tb[5] = '{8'd7,   8'd1,   8'd255, 8'd9, 8'd3};
    int lat; logic bok; logic [16:0] exp;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], lat, bok);
      exp = model(ta[i], tb[i]);
      n_checks++;
      if (lat != 10) begin
        n_fails++;
        $display("FAIL latency %0d/%0d: got %0d edges, want 10", ta[i], tb[i], lat);
      end
      n_checks++;
      if ({div_zero, quotient, remainder} !== exp) begin
        n_fails++;
        $display("FAIL result %0d/%0d: dz=%b q=%0d r=%0d, want dz=%b q=%0d r=%0d",
                 ta[i], tb[i], div_zero, quotient, remainder, exp[16], exp[15:8], exp[7:0]);
      end
      n_checks++;
      if (!bok) begin
        n_fails++;
        $display("FAIL busy %0d/%0d: Busy low before Done, want high", ta[i], tb[i]);
      end
      end_op();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {div_zero, quotient, remainder} !== exp) begin
        n_fails++;
        $display("FAIL idle_hold %0d/%0d: done=%b busy=%b q=%0d r=%0d, want 0 0 q=%0d r=%0d",
                 ta[i], tb[i], done, busy, quotient, remainder, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic bok;
    run_op(8'd200, 8'd0, lat, bok);
    n_checks++;
    if (lat != 2) begin
      n_fails++;
      $display("FAIL dz_latency: got %0d edges, want 2", lat);
    end
    n_checks++;
    if ({div_zero, quotient, remainder} !== {1'b1, 8'hFF, 8'hC8}) begin
      n_fails++;
      $display("FAIL dz_result: dz=%b q=%h r=%h, want 1 ff c8", div_zero, quotient, remainder);
    end
    end_op();
    run_op(8'd10, 8'd3, lat, bok);
    n_checks++;
    if ({div_zero, quotient, remainder} !== {1'b0, 8'd3, 8'd1} || lat != 10) begin
      n_fails++;
      $display("FAIL after_dz: dz=%b q=%0d r=%0d lat=%0d, want 0 3 1 lat 10",
               div_zero, quotient, remainder, lat);
    end
    end_op();
  endtask

  task automatic test_hold_start();
    int lat; logic bok; int bad = 0;
    run_op(8'd100, 8'd7, lat, bok);
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL hold_done: %0d unstable cycles, last done=%b q=%0d r=%0d, want 0 (1 14 2)",
               bad, done, quotient, remainder);
    end
    end_op();
    n_checks++;
    if (done !== 1'b0 || dbg_state !== 2'd0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fails++;
      $display("FAIL hold_release: done=%b st=%0d q=%0d r=%0d, want 0 0 14 2",
               done, dbg_state, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic bok;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    repeat (6) @(posedge clk);  // start edge, LOAD edge, four ITER edges
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({quotient, remainder, busy, done, div_zero, dbg_state} !== 21'd0) begin
      n_fails++;
      $display("FAIL reset_abort: q=%0d r=%0d busy=%b done=%b dz=%b st=%0d, want all zero",
               quotient, remainder, busy, done, div_zero, dbg_state);
    end
    @(negedge clk); rst = 1'b0;
    run_op(8'd100, 8'd7, lat, bok);
    n_checks++;
    if ({quotient, remainder} !== {8'd14, 8'd2} || lat != 10) begin
      n_fails++;
      $display("FAIL rerun: q=%0d r=%0d lat=%0d, want 14 2 lat 10", quotient, remainder, lat);
    end
    end_op();
  endtask

  task automatic test_input_change();
    int lat = 1;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd0; divisor = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    n_checks++;
    if ({done, div_zero, quotient, remainder} !== {1'b1, 1'b0, 8'd14, 8'd2} || lat != 10) begin
      n_fails++;
      $display("FAIL input_change: done=%b dz=%b q=%0d r=%0d lat=%0d, want 1 0 14 2 lat 10",
               done, div_zero, quotient, remainder, lat);
    end
    end_op();
  endtask

  task automatic test_random();
    int lat; logic bok; logic [7:0] a, b; logic [16:0] exp;
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      exp_q.push_back(model(a, b));
      run_op(a, b, lat, bok);
      exp = exp_q.pop_front();
      n_checks++;
      if ({div_zero, quotient, remainder} !== exp || lat != ((b == 0) ? 2 : 10)) begin
        n_fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random %0d/%0d: dz=%b q=%0d r=%0d lat=%0d, want dz=%b q=%0d r=%0d",
                   a, b, div_zero, quotient, remainder, lat, exp[16], exp[15:8], exp[7:0]);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      end_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_hold_start();
    test_reset_abort();
    test_input_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
